// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b computed LSB first as a + ~b + 1
// through a single full-adder cell with a registered carry, one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sgn_a_q, sgn_a_d;
  logic             sgn_b_q, sgn_b_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       fa;

  // Returns {carry_out, sum} of a one-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    res_d      = res_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    sgn_a_d    = sgn_a_q;
    sgn_b_d    = sgn_b_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    fa         = 2'b00;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtrahend is inverted here; the +1 comes from the initial carry.
          sa_d    = a;
          sb_d    = ~b;
          res_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
          sgn_a_d = a[WIDTH-1];
          sgn_b_d = b[WIDTH-1];
          state_d = RUN;
        end
      end

      RUN: begin
        fa      = full_add(sa_q[0], sb_q[0], carry_q);
        res_d   = (res_q >> 1) | {fa[0], {(WIDTH-1){1'b0}}};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa[1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d     = res_d;
          borrow_d   = ~fa[1];
          overflow_d = (sgn_a_q ^ sgn_b_q) & (fa[0] ^ sgn_a_q);
          cnt_d      = '0;
          state_d    = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      res_q      <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      sgn_a_q    <= 1'b0;
      sgn_b_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      res_q      <= res_d;
      diff_q     <= diff_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      sgn_a_q    <= sgn_a_d;
      sgn_b_q    <= sgn_b_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  // Status outputs decode the state register only, so no input reaches them combinationally.
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor for the ALU datapath. It computes `diff = a - b` one bit per clock, LSB first, by chaining a single full-adder cell with a registered carry (`a + ~b + 1`). It trades WIDTH cycles of latency for a one-bit datapath. A start/done handshake lets the ALU controller issue operands and collect the result, borrow and signed-overflow flags.

## Interface
- `WIDTH`, default 64: operand and result width in bits; legal range 2..64.

- `clk`  input  1  : system clock; all state updates on the rising edge.
- `rst_n`  input  1  : asynchronous, active-low reset.
- `start`  input  1  : request a subtraction; sampled on the rising edge.
- `a`  input  WIDTH  : minuend; captured on the accepted `start` edge.
- `b`  input  WIDTH  : subtrahend; captured on the accepted `start` edge.
- `busy`  output  1  : high while a subtraction is in progress (state RUN).
- `done`  output  1  : one-cycle pulse; the result is valid.
- `diff`  output  WIDTH  : `a - b` modulo 2^WIDTH; holds until the next accepted `start`.
- `borrow`  output  1  : unsigned borrow, i.e. `a < b` unsigned (inverse of final carry-out).
- `overflow`  output  1  : signed overflow, set when `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- Internal state:
  - FSM states IDLE, RUN, DONE.
  - Shift registers `sa` and `sb` (WIDTH each).
  - Result shift register (WIDTH).
  - Carry flop.
  - Bit counter, `$clog2(WIDTH)` bits.
  - Latched operand sign bits.
- **IDLE**
  - `start=1` → load `sa=a` and `sb=~b`, set carry to 1, set count to 0, latch `a[MSB]` and `b[MSB]`, go to RUN.
  - `start=0` → stay in IDLE.
- **RUN**, on each edge:
  - Compute `s = sa[0]^sb[0]^carry` and `c = majority(sa[0], sb[0], carry)`.
  - Shift `s` into the result MSB with a right shift.
  - Shift `sa` and `sb` right by one and set carry to `c`.
  - Increment the counter.
  - On the edge that processes bit WIDTH-1 (count == WIDTH-1):
    - copy the result into `diff`;
    - set `borrow = ~c`;
    - compute `overflow` from the latched signs and the final sum bit;
    - go to DONE.
- **DONE**, one cycle, with `done=1`:
  - `start=1` → accepted exactly as in IDLE; go straight to RUN.
  - `start=0` → go to IDLE.
- `start` in RUN is ignored. It is not queued, and operands are not re-captured.
- `a` and `b` may change freely after the capture edge.
- `diff`, `borrow` and `overflow` update only on the completing edge. They are stable from then until the next completion.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state becomes IDLE;
  - `busy=0`, `done=0`, `diff=0`, `borrow=0`, `overflow=0`;
  - counter, carry and shift registers are cleared.
- Reset asserted mid-RUN aborts the operation. No `done` pulse is produced.
- Deassertion of reset is not required to be synchronous to `clk`. The first `start` sampled after release is honoured.
- Let the `start` capture be edge E0:
  - `busy` is high in the cycles after E0 through E0+WIDTH-1;
  - the result registers update at E0+WIDTH;
  - `done` is high for exactly the cycle after E0+WIDTH.
- Latency is WIDTH+1 edges from the capture edge to the end of the `done` pulse. Sustained throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high together. Both are registered outputs with no combinational path from any input.

## Test plan
Bench uses WIDTH=8.
- **Basic:** after reset, `a=5`, `b=3`, one-cycle `start` → `busy` high for 8 cycles, then `done` 1 cycle, `diff=0x02`, `borrow=0`, `overflow=0`.
- **Negative result:** `a=3`, `b=5` → `diff=0xFE`, `borrow=1`, `overflow=0`.
- **Overflow and edge values:**
  - `a=0x80`, `b=0x01` → `diff=0x7F`, `borrow=0`, `overflow=1`;
  - `a=0x00`, `b=0x00` → `diff=0x00`, all flags 0;
  - `a=0xFF`, `b=0xFF` → `diff=0x00`, `borrow=0`.
- **Start while busy:** issue `a=9`, `b=4`; 3 cycles later pulse `start` with `a=1`, `b=1` → a single `done` at the original time, `diff=0x05`.
- **Back-to-back:** hold `start=1` with new operands (`a=0x10`, `b=0x20`) during the `done` cycle → next `done` exactly 9 cycles later, `diff=0xF0`, `borrow=1`.
- **Reset mid-operation:** drop `rst_n` 4 cycles into RUN → all outputs 0 immediately, no `done` pulse; a fresh `start` afterwards completes normally.
